vga_timing_rx: RTL and testbench

VGA_TIMING_RX -- requirements
Module: vga_timing_rx

---
 rtl/vga_timing_rx.sv | 186 ++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rx.sv
// ============================================================================
// Module   : vga_timing_rx
// Function : Recovers pixel position, data enable and lock status from an
//            incoming hsync/vsync pair, flagging horizontal/vertical errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_rx #(
    parameter int H_TOTAL     = 800,
    parameter int H_PULSE     = 96,
    parameter int H_BP        = 144,
    parameter int H_FP        = 784,
    parameter int V_TOTAL     = 521,
    parameter int V_PULSE     = 2,
    parameter int V_BP        = 31,
    parameter int V_FP        = 511,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       locked,
    output logic       frame_start,
    output logic       h_err,
    output logic       v_err
);

    localparam int         CNT_W        = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0] POS_MAX      = 10'h3FF;
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_PULSE_LAST = 10'(H_PULSE - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_PULSE_LAST = 10'(V_PULSE - 1);
    localparam logic [9:0] H_BP_POS     = 10'(H_BP);
    localparam logic [9:0] H_FP_POS     = 10'(H_FP);
    localparam logic [9:0] V_BP_POS     = 10'(V_BP);
    localparam logic [9:0] V_FP_POS     = 10'(V_FP);
    localparam logic [9:0] H_ACT0       = 10'(H_BP + 1);
    localparam logic [9:0] V_ACT0       = 10'(V_BP + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    logic             hs_dly_q;
    logic             vs_dly_q;
    logic [9:0]       hpos_q;
    logic [9:0]       hpos_d;
    logic [9:0]       vpos_q;
    logic [9:0]       vpos_d;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             dirty_q;
    logic             h_err_q;
    logic             h_err_d;
    logic             v_err_q;
    logic             v_err_d;

    logic hs_fall;
    logic hs_rise;
    logic vs_fall;
    logic vs_rise;
    logic sync_lost;
    logic good_frame;

    assign hs_fall = hs_dly_q & ~hsync_in;
    assign hs_rise = ~hs_dly_q & hsync_in;
    assign vs_fall = vs_dly_q & ~vsync_in;
    assign vs_rise = ~vs_dly_q & vsync_in;

    always_comb begin
        hpos_d = (hpos_q == POS_MAX) ? hpos_q : hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (hs_fall) begin
            hpos_d = '0;
            if (vs_fall) begin
                vpos_d = '0;
            end else if (vpos_q != POS_MAX) begin
                vpos_d = vpos_q + 10'd1;
            end
        end
    end

    always_comb begin
        h_err_d = 1'b0;
        v_err_d = 1'b0;
        if (state_q != HUNT) begin
            h_err_d = (hs_fall && (hpos_q != H_LAST)) ||
                      (hs_rise && (hpos_q != H_PULSE_LAST));
            v_err_d = ((vs_fall || vs_rise) && !hs_fall) ||
                      (vs_fall && (vpos_q != V_LAST)) ||
                      (vs_rise && hs_fall && (vpos_q != V_PULSE_LAST));
        end
    end

    // A saturated counter means the sync stream has gone away entirely.
    assign sync_lost  = (hpos_d == POS_MAX) || (vpos_d == POS_MAX);
    assign cnt_inc    = cnt_q + 1'b1;
    assign good_frame = vs_fall && hs_fall && (vpos_q == V_LAST) && !dirty_q &&
                        !h_err_d && !v_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_dly_q <= 1'b1;
            vs_dly_q <= 1'b1;
            hpos_q   <= '0;
            vpos_q   <= '0;
        end else begin
            hs_dly_q <= hsync_in;
            vs_dly_q <= vsync_in;
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
        end
    end

    // Errors act on the FSM through their registered pulses, so lock drops
    // on the cycle after the pulse is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            dirty_q <= 1'b0;
            h_err_q <= 1'b0;
            v_err_q <= 1'b0;
        end else begin
            h_err_q <= h_err_d;
            v_err_q <= v_err_d;
            if (sync_lost) begin
                state_q <= HUNT;
                cnt_q   <= '0;
                dirty_q <= 1'b0;
            end else begin
                case (state_q)
                    HUNT: begin
                        if (hs_fall && vs_fall) begin
                            state_q <= TRACK;
                            cnt_q   <= '0;
                            dirty_q <= 1'b0;
                        end
                    end
                    TRACK, LOCKED: begin
                        if (h_err_q || v_err_q) begin
                            state_q <= TRACK;
                            cnt_q   <= '0;
                            dirty_q <= 1'b1;
                        end else if (vs_fall) begin
                            dirty_q <= 1'b0;
                            if ((state_q == TRACK) && good_frame) begin
                                cnt_q <= cnt_inc;
                                if (cnt_inc == CNT_W'(LOCK_FRAMES)) begin
                                    state_q <= LOCKED;
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        cnt_q   <= '0;
                        dirty_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked      = (state_q == LOCKED);
    assign de          = locked &&
                         (hpos_q > H_BP_POS) && (hpos_q < H_FP_POS) &&
                         (vpos_q > V_BP_POS) && (vpos_q <= V_FP_POS);
    assign x           = de ? (hpos_q - H_ACT0) : '0;
    assign y           = de ? (vpos_q - V_ACT0) : '0;
    assign frame_start = (state_q != HUNT) && (hpos_q == '0) && (vpos_q == '0);
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_rx.sv
// ============================================================================
// Module   : tb_vga_timing_rx
// Function : Directed self-checking bench for vga_timing_rx on a scaled-down
//            raster (40 clocks x 20 lines) so whole frames stay short.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_rx;

    localparam int H_TOTAL = 40;
    localparam int H_PULSE = 4;
    localparam int H_BP    = 8;
    localparam int H_FP    = 36;
    localparam int V_TOTAL = 20;
    localparam int V_PULSE = 2;
    localparam int V_BP    = 4;
    localparam int V_FP    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       locked;
    logic       frame_start;
    logic       h_err;
    logic       v_err;

    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;
    int   herr_cnt = 0;
    int   verr_cnt = 0;
    int   fs_cnt = 0;
    int   vfalls = 0;
    int   lock_at_vfall = -1;
    int   vlow_lines = V_PULSE;
    logic locked_prev = 1'b0;
    logic vs_prev_drv = 1'b1;

    vga_timing_rx #(
        .H_TOTAL    (H_TOTAL),
        .H_PULSE    (H_PULSE),
        .H_BP       (H_BP),
        .H_FP       (H_FP),
        .V_TOTAL    (V_TOTAL),
        .V_PULSE    (V_PULSE),
        .V_BP       (V_BP),
        .V_FP       (V_FP),
        .LOCK_FRAMES(2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .x          (x),
        .y          (y),
        .de         (de),
        .locked     (locked),
        .frame_start(frame_start),
        .h_err      (h_err),
        .v_err      (v_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One input sample; returns 1 time unit after the edge that captured it.
    task automatic pixel(input logic hs, input logic vs);
        if (vs_prev_drv && !vs) vfalls++;
        vs_prev_drv = vs;
        hsync_in = hs;
        vsync_in = vs;
        @(posedge clk);
        #1;
        if (h_err === 1'b1) herr_cnt++;
        if (v_err === 1'b1) verr_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
        if ((locked === 1'b1) && !locked_prev) lock_at_vfall = vfalls;
        locked_prev = (locked === 1'b1);
    endtask

    task automatic drive_cols(input int ln, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            pixel((c >= H_PULSE) ? 1'b1 : 1'b0, (ln >= vlow_lines) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic frame_lines(input int l0, input int l1);
        for (int ln = l0; ln <= l1; ln++) begin
            drive_cols(ln, 0, H_TOTAL - 1);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) pixel(1'b1, 1'b1);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_de", 32'(de), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_h_err", 32'(h_err), 0);
        chk("rst_v_err", 32'(v_err), 0);
        rst_n = 1'b1;

        // Three nominal frames: lock on the third vsync fall
        repeat (3) frame_lines(0, V_TOTAL - 1);
        chk("lock_vfall_nominal", 32'(lock_at_vfall), 3);
        chk("locked_nominal", 32'(locked), 1);
        chk("herr_nominal", 32'(herr_cnt), 0);
        chk("verr_nominal", 32'(verr_cnt), 0);
        chk("frame_start_count", 32'(fs_cnt), 3);

        // Active-window boundaries (frame 3)
        frame_lines(0, 4);
        drive_cols(5, 0, 8);
        chk("de_hpos8", 32'(de), 0);
        drive_cols(5, 9, 9);
        chk("de_first", 32'(de), 1);
        chk("x_first", 32'(x), 0);
        chk("y_first", 32'(y), 0);
        drive_cols(5, 10, H_TOTAL - 1);
        frame_lines(6, 15);
        drive_cols(16, 0, 35);
        chk("de_last", 32'(de), 1);
        chk("x_last", 32'(x), 26);
        chk("y_last", 32'(y), 11);
        drive_cols(16, 36, 36);
        chk("de_hfp", 32'(de), 0);
        chk("x_hfp", 32'(x), 0);
        drive_cols(16, 37, H_TOTAL - 1);
        drive_cols(17, 0, 20);
        chk("de_vfp", 32'(de), 0);
        drive_cols(17, 21, H_TOTAL - 1);
        frame_lines(18, V_TOTAL - 1);

        // Short line in frame 4
        frame_lines(0, 6);
        drive_cols(7, 0, H_TOTAL - 2);
        drive_cols(8, 0, 0);
        chk("short_h_err_pulse", 32'(h_err), 1);
        chk("short_locked_hold", 32'(locked), 1);
        drive_cols(8, 1, 1);
        chk("short_h_err_clear", 32'(h_err), 0);
        chk("short_locked_drop", 32'(locked), 0);
        drive_cols(8, 2, H_TOTAL - 1);
        frame_lines(9, V_TOTAL - 1);
        repeat (2) frame_lines(0, V_TOTAL - 1);
        chk("relock_pending", 32'(locked), 0);
        frame_lines(0, V_TOTAL - 1);
        chk("relock", 32'(locked), 1);
        chk("relock_vfall", 32'(lock_at_vfall), 8);
        chk("short_herr_total", 32'(herr_cnt), 1);
        chk("short_verr_total", 32'(verr_cnt), 0);

        // Vsync held low three lines (frame 8)
        vlow_lines = 3;
        frame_lines(0, 2);
        drive_cols(3, 0, 0);
        chk("vlong_v_err_pulse", 32'(v_err), 1);
        chk("vlong_locked_hold", 32'(locked), 1);
        drive_cols(3, 1, 1);
        chk("vlong_v_err_clear", 32'(v_err), 0);
        chk("vlong_locked_drop", 32'(locked), 0);
        drive_cols(3, 2, H_TOTAL - 1);
        frame_lines(4, V_TOTAL - 1);
        vlow_lines = V_PULSE;
        chk("vlong_verr_total", 32'(verr_cnt), 1);
        drive_cols(0, 0, 0);
        chk("track_frame_start", 32'(frame_start), 1);
        chk("track_locked", 32'(locked), 0);
        drive_cols(0, 1, H_TOTAL - 1);

        // Hsync stuck high: saturate, fall back to HUNT, no further errors
        repeat (1100) pixel(1'b1, 1'b0);
        chk("stuck_locked", 32'(locked), 0);
        chk("stuck_de", 32'(de), 0);
        frame_lines(2, V_TOTAL - 1);
        chk("stuck_herr_total", 32'(herr_cnt), 1);
        chk("stuck_verr_total", 32'(verr_cnt), 1);
        repeat (3) frame_lines(0, V_TOTAL - 1);
        chk("stuck_relock_vfall", 32'(lock_at_vfall), 13);
        chk("stuck_relock", 32'(locked), 1);

        // Asynchronous reset mid-line while locked (frame 13)
        frame_lines(0, 6);
        drive_cols(7, 0, 20);
        chk("pre_rst_de", 32'(de), 1);
        chk("pre_rst_x", 32'(x), 11);
        chk("pre_rst_y", 32'(y), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_de", 32'(de), 0);
        chk("async_rst_x", 32'(x), 0);
        chk("async_rst_y", 32'(y), 0);
        chk("async_rst_locked", 32'(locked), 0);
        chk("async_rst_frame_start", 32'(frame_start), 0);
        chk("async_rst_h_err", 32'(h_err), 0);
        chk("async_rst_v_err", 32'(v_err), 0);
        drive_cols(7, 21, 25);
        rst_n = 1'b1;
        drive_cols(7, 26, H_TOTAL - 1);
        frame_lines(8, V_TOTAL - 1);
        repeat (3) frame_lines(0, V_TOTAL - 1);
        chk("rst_relock_vfall", 32'(lock_at_vfall), 17);
        chk("rst_relock", 32'(locked), 1);
        chk("final_herr_total", 32'(herr_cnt), 1);
        chk("final_verr_total", 32'(verr_cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
